// File: rtl/usb_rx_sequencer.sv
// USB receive sequencer: SYNC hunt, bit destuffing, LSB-first byte packing and EOP detection.
// Optional saturating error counter is built when USB_RX_ERR_CNT_EN is defined.
module usb_rx_sequencer #(
  parameter int SYNC_MIN_ZEROS = 4,
  parameter int MAX_BYTES      = 64,
  parameter int IDLE_J_CYCLES  = 8
) (
  input  logic                               clk,
  input  logic                               nRST,
  input  logic                               rx_dp,
  input  logic                               rx_dm,
  input  logic                               dec_bit,
  output logic                               dec_en,
  output logic                               rx_active,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid,
  output logic [$clog2(MAX_BYTES+1)-1:0]     rx_count,
  output logic                               eop,
  output logic                               rx_error,
  output logic [7:0]                         err_count
);
  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int JW = $clog2(IDLE_J_CYCLES + 1);
  localparam logic [1:0] LN_J   = 2'b10;
  localparam logic [1:0] LN_K   = 2'b01;
  localparam logic [1:0] LN_SE0 = 2'b00;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

  state_t        state;
  logic [1:0]    line_now, line_d;
  logic          sync_first;
  logic [2:0]    zero_cnt;
  logic [2:0]    ones_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shift_reg;
  logic [1:0]    se0_cnt;
  logic [JW-1:0] j_cnt;

  logic data_se0, stuff_pend, stuff_err, partial_err, byte_done, overflow_err, eop_err, err_now;

  assign line_now = {rx_dp, rx_dm};

  // dec_bit and line_d describe the same line sample, so every DATA/EOP decision uses line_d.
  assign data_se0     = (state == S_DATA) && (line_d == LN_SE0);
  assign stuff_pend   = (ones_cnt == 3'd6);
  assign stuff_err    = (state == S_DATA) && !data_se0 && stuff_pend && dec_bit;
  assign partial_err  = data_se0 && (bit_cnt != 3'd0);
  assign byte_done    = (state == S_DATA) && !data_se0 && !stuff_pend && (bit_cnt == 3'd7);
  assign overflow_err = byte_done && (rx_count == CW'(MAX_BYTES));
  assign eop_err      = (state == S_EOP) &&
                        ((line_d == LN_K) || ((line_d == LN_SE0) && (se0_cnt == 2'd3)));
  assign err_now      = stuff_err || partial_err || overflow_err || eop_err;

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state      <= S_IDLE;
      line_d     <= 2'b00;
      sync_first <= 1'b0;
      zero_cnt   <= 3'd0;
      ones_cnt   <= 3'd0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 7'd0;
      se0_cnt    <= 2'd0;
      j_cnt      <= '0;
      dec_en     <= 1'b0;
      rx_active  <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_count   <= '0;
      eop        <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      line_d   <= line_now;
      rx_valid <= 1'b0;
      eop      <= 1'b0;
      rx_error <= 1'b0;
      if (err_now) begin
        state     <= S_ERROR;
        rx_error  <= 1'b1;
        rx_active <= 1'b0;
        dec_en    <= 1'b0;
        j_cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (line_now == LN_K) begin
              state      <= S_SYNC;
              dec_en     <= 1'b1;
              sync_first <= 1'b1;
              zero_cnt   <= 3'd0;
            end
          end
          S_SYNC: begin
            // First decoded bit after enabling is the decoder's forced idle 1.
            if (sync_first) begin
              sync_first <= 1'b0;
            end else if (line_d == LN_SE0) begin
              state  <= S_IDLE;
              dec_en <= 1'b0;
            end else if (!dec_bit) begin
              if (zero_cnt == 3'd6) begin
                state  <= S_IDLE;
                dec_en <= 1'b0;
              end else begin
                zero_cnt <= zero_cnt + 3'd1;
              end
            end else if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
              state     <= S_DATA;
              rx_active <= 1'b1;
              rx_count  <= '0;
              ones_cnt  <= 3'd0;
              bit_cnt   <= 3'd0;
            end else begin
              state  <= S_IDLE;
              dec_en <= 1'b0;
            end
          end
          S_DATA: begin
            if (line_d == LN_SE0) begin
              state   <= S_EOP;
              se0_cnt <= 2'd1;
            end else if (stuff_pend) begin
              ones_cnt <= 3'd0;
            end else begin
              ones_cnt  <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
              shift_reg <= {dec_bit, shift_reg[6:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (byte_done) begin
                rx_data  <= {dec_bit, shift_reg};
                rx_valid <= 1'b1;
                rx_count <= rx_count + CW'(1);
              end
            end
          end
          S_EOP: begin
            if (line_d == LN_J) begin
              state     <= S_IDLE;
              eop       <= 1'b1;
              rx_active <= 1'b0;
              dec_en    <= 1'b0;
            end else if (line_d == LN_SE0) begin
              se0_cnt <= se0_cnt + 2'd1;
            end
          end
          S_ERROR: begin
            if (line_now == LN_J) begin
              if (j_cnt == JW'(IDLE_J_CYCLES - 1)) begin
                state <= S_IDLE;
                j_cnt <= '0;
              end else begin
                j_cnt <= j_cnt + JW'(1);
              end
            end else begin
              j_cnt <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef USB_RX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;
  always_ff @(posedge clk) begin
    if (!nRST)
      err_cnt_reg <= 8'h00;
    else if (rx_error && (err_cnt_reg != 8'hFF))
      err_cnt_reg <= err_cnt_reg + 8'h01;
  end
  assign err_count = err_cnt_reg;
`else
  assign err_count = 8'h00;
`endif

endmodule
